// File: rtl/operand_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_pkg
// Brief    : Shared core constants, register-file types and operand-fetch
//            state encoding.
// Revision : 1.0
// ============================================================================
package operand_fetch_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    typedef logic [$clog2(NREGS)-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]          xlen_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } of_state_e;

endpackage
`default_nettype wire

// File: rtl/operand_bypass.sv
`default_nettype none
// ============================================================================
// Module   : operand_bypass
// Brief    : Per-port operand priority mux: same-cycle writeback, then a
//            latched forward, then the base value. Index 0 always reads 0.
// Revision : 1.0
// ============================================================================
module operand_bypass #(
    parameter int N_REGS_P  = 32,
    parameter int WD_REGS_P = 32
) (
    input  logic [$clog2(N_REGS_P)-1:0] i_rs,
    input  logic                        i_wb_en,
    input  logic [$clog2(N_REGS_P)-1:0] i_wb_addr,
    input  logic [WD_REGS_P-1:0]        i_wb_data,
    input  logic                        i_fwd,
    input  logic [WD_REGS_P-1:0]        i_fwd_data,
    input  logic [WD_REGS_P-1:0]        i_base,
    output logic [WD_REGS_P-1:0]        o_data
);

    always_comb begin
        o_data = i_base;
        if (i_rs == '0)
            o_data = '0;
        else if (i_wb_en && (i_wb_addr == i_rs))
            o_data = i_wb_data;
        else if (i_fwd)
            o_data = i_fwd_data;
    end

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Brief    : Register-file read client; hides the one-cycle read latency,
//            forwards writebacks, and hands operands to execute.
// Revision : 1.0
// ============================================================================
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int N_REGS_P     = NREGS,
    parameter int WD_REGS_P    = XLEN,
    parameter int WD_PAYLOAD_P = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_flush,
    input  logic                              i_dec_valid,
    output logic                              o_dec_ready,
    input  logic [$clog2(N_REGS_P)-1:0]       i_dec_rs1,
    input  logic [$clog2(N_REGS_P)-1:0]       i_dec_rs2,
    input  logic [WD_PAYLOAD_P-1:0]           i_dec_payload,
    output logic [1:0][$clog2(N_REGS_P)-1:0]  o_reg_rd_addr,
    input  logic [1:0][WD_REGS_P-1:0]         i_reg_rd_data,
    input  logic                              i_wb_en,
    input  logic [$clog2(N_REGS_P)-1:0]       i_wb_addr,
    input  logic [WD_REGS_P-1:0]              i_wb_data,
    output logic                              o_op_valid,
    input  logic                              i_op_ready,
    output logic [WD_REGS_P-1:0]              o_op_rs1_data,
    output logic [WD_REGS_P-1:0]              o_op_rs2_data,
    output logic [WD_PAYLOAD_P-1:0]           o_op_payload
);

    localparam int c_wd_addr = $clog2(N_REGS_P);

    of_state_e                         r_state;
    logic                              r_op_valid;
    logic [1:0][c_wd_addr-1:0]         r_rs;
    logic [WD_PAYLOAD_P-1:0]           r_payload;
    logic [1:0]                        r_fwd;
    logic [1:0][WD_REGS_P-1:0]         r_fwd_data;
    logic [1:0][WD_REGS_P-1:0]         r_held;

    logic                              w_dec_fire;
    logic                              w_op_fire;
    logic [1:0][c_wd_addr-1:0]         w_dec_rs;
    logic [1:0][WD_REGS_P-1:0]         w_op;

    assign o_dec_ready = !r_op_valid || i_op_ready;
    assign w_dec_fire  = i_dec_valid && o_dec_ready;
    assign w_op_fire   = r_op_valid && i_op_ready;
    assign w_dec_rs    = {i_dec_rs2, i_dec_rs1};

    assign o_reg_rd_addr = o_dec_ready ? w_dec_rs : r_rs;

    generate
        for (genvar s = 0; s < 2; s++) begin : g_port
            // Register-file data only matters in FETCH; HOLD serves its own copy.
            operand_bypass #(
                .N_REGS_P  (N_REGS_P),
                .WD_REGS_P (WD_REGS_P)
            ) u_bypass (
                .i_rs       (r_rs[s]),
                .i_wb_en    (i_wb_en),
                .i_wb_addr  (i_wb_addr),
                .i_wb_data  (i_wb_data),
                .i_fwd      (r_fwd[s]),
                .i_fwd_data (r_fwd_data[s]),
                .i_base     ((r_state == FETCH) ? i_reg_rd_data[s] : r_held[s]),
                .o_data     (w_op[s])
            );
        end
    endgenerate

    assign o_op_valid    = r_op_valid;
    assign o_op_rs1_data = r_op_valid ? w_op[0] : '0;
    assign o_op_rs2_data = r_op_valid ? w_op[1] : '0;
    assign o_op_payload  = r_op_valid ? r_payload : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_op_valid <= 1'b0;
            r_rs       <= '0;
            r_payload  <= '0;
            r_fwd      <= '0;
            r_fwd_data <= '0;
            r_held     <= '0;
        end else begin
            // The register file returns the stale value for a write landing on the accept edge.
            if (w_dec_fire && !i_flush) begin
                r_rs      <= w_dec_rs;
                r_payload <= i_dec_payload;
                for (int s = 0; s < 2; s++) begin
                    r_fwd[s]      <= i_wb_en && (i_wb_addr == w_dec_rs[s]) && (w_dec_rs[s] != '0);
                    r_fwd_data[s] <= i_wb_data;
                end
            end

            if (i_flush) begin
                r_state    <= IDLE;
                r_op_valid <= 1'b0;
                r_fwd      <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_dec_fire) begin
                            r_state    <= FETCH;
                            r_op_valid <= 1'b1;
                        end
                    end
                    FETCH, HOLD: begin
                        if (w_op_fire) begin
                            r_state    <= w_dec_fire ? FETCH : IDLE;
                            r_op_valid <= w_dec_fire;
                        end else begin
                            r_state <= HOLD;
                            r_held  <= w_op;
                            r_fwd   <= '0;
                        end
                    end
                    default: begin
                        r_state    <= IDLE;
                        r_op_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_fetch
// Brief    : Scoreboard bench for operand_fetch with a registered-read
//            register-file model.
// Revision : 1.0
// ============================================================================
module tb_operand_fetch;

    logic                  clk;
    logic                  rst_n;
    logic                  flush;
    logic                  dec_valid;
    logic                  dec_ready;
    logic [4:0]            dec_rs1;
    logic [4:0]            dec_rs2;
    logic [63:0]           dec_payload;
    logic [1:0][4:0]       rd_addr;
    logic [1:0][31:0]      rd_data;
    logic                  wb_en;
    logic [4:0]            wb_addr;
    logic [31:0]           wb_data;
    logic                  op_valid;
    logic                  op_ready;
    logic [31:0]           op_rs1;
    logic [31:0]           op_rs2;
    logic [63:0]           op_payload;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [63:0] payload;
    } exp_t;

    exp_t exp_q[$];
    logic [31:0] rf [32];

    operand_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_flush       (flush),
        .i_dec_valid   (dec_valid),
        .o_dec_ready   (dec_ready),
        .i_dec_rs1     (dec_rs1),
        .i_dec_rs2     (dec_rs2),
        .i_dec_payload (dec_payload),
        .o_reg_rd_addr (rd_addr),
        .i_reg_rd_data (rd_data),
        .i_wb_en       (wb_en),
        .i_wb_addr     (wb_addr),
        .i_wb_data     (wb_data),
        .o_op_valid    (op_valid),
        .i_op_ready    (op_ready),
        .o_op_rs1_data (op_rs1),
        .o_op_rs2_data (op_rs2),
        .o_op_payload  (op_payload)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: registered read that returns the pre-write value on a collision.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'h0 : 32'h1000 + i;
            rf[3]   <= 32'h11;
            rf[4]   <= 32'h22;
            rf[5]   <= 32'h1;
            rd_data <= '0;
        end else begin
            if (wb_en && wb_addr != 5'd0) rf[wb_addr] <= wb_data;
            rd_data[0] <= rf[rd_addr[0]];
            rd_data[1] <= rf[rd_addr[1]];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every operand handoff must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && op_valid && op_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_fire", 64'h1, 64'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_rs1", {32'h0, op_rs1}, {32'h0, e.rs1});
                chk("sb_rs2", {32'h0, op_rs2}, {32'h0, e.rs2});
                chk("sb_payload", op_payload, e.payload);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [63:0] p);
        dec_valid   = 1'b1;
        dec_rs1     = r1;
        dec_rs2     = r2;
        dec_payload = p;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
        exp_t e;
        e.rs1 = a; e.rs2 = b; e.payload = p;
        exp_q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0;
        dec_payload = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0; op_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_op_valid", {63'h0, op_valid}, 64'h0);
        chk("rst_dec_ready", {63'h0, dec_ready}, 64'h1);
        chk("rst_rs1", {32'h0, op_rs1}, 64'h0);
        chk("rst_payload", op_payload, 64'h0);
        rst_n = 1'b1;
        step();

        // Back-to-back issue, no bubble
        op_ready = 1'b1;
        drive(5'd3, 5'd4, 64'hA1); push(32'h11, 32'h22, 64'hA1);
        step();
        chk("b2b_valid", {63'h0, op_valid}, 64'h1);
        chk("b2b_dec_ready", {63'h0, dec_ready}, 64'h1);
        drive(5'd4, 5'd3, 64'hA2); push(32'h22, 32'h11, 64'hA2);
        step();
        chk("b2b_second_valid", {63'h0, op_valid}, 64'h1);
        dec_valid = 1'b0;
        step();
        chk("b2b_drain", {63'h0, op_valid}, 64'h0);

        // Acceptance-cycle hazard
        drive(5'd5, 5'd0, 64'hA3); push(32'hDEAD, 32'h0, 64'hA3);
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD;
        step();
        wb_en = 1'b0; dec_valid = 1'b0;
        #1;
        chk("hazard_rs1", {32'h0, op_rs1}, 64'hDEAD);
        step();

        // Stall with late write to rs2
        op_ready = 1'b0;
        drive(5'd3, 5'd7, 64'hA4);
        step();
        dec_valid = 1'b0;
        #1;
        chk("stall1_rs2", {32'h0, op_rs2}, 64'h1007);
        step();
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hBEEF;
        #1;
        chk("stall2_rs2", {32'h0, op_rs2}, 64'hBEEF);
        chk("stall2_payload", op_payload, 64'hA4);
        step();
        wb_en = 1'b0;
        #1;
        chk("stall3_rs2", {32'h0, op_rs2}, 64'hBEEF);
        chk("stall3_payload", op_payload, 64'hA4);
        push(32'h11, 32'hBEEF, 64'hA4);
        op_ready = 1'b1;
        step();
        chk("stall_drain", {63'h0, op_valid}, 64'h0);

        // x0 guard
        drive(5'd0, 5'd4, 64'hA5); push(32'h0, 32'h22, 64'hA5);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        step();
        dec_valid = 1'b0;
        #1;
        chk("x0_rs1", {32'h0, op_rs1}, 64'h0);
        step();
        wb_en = 1'b0;

        // Flush while holding, new instruction offered
        op_ready = 1'b0;
        drive(5'd3, 5'd4, 64'hA6);
        step();
        dec_valid = 1'b0;
        step();
        chk("flush_pre_valid", {63'h0, op_valid}, 64'h1);
        flush = 1'b1;
        drive(5'd4, 5'd3, 64'hA7);
        step();
        flush = 1'b0; dec_valid = 1'b0;
        #1;
        chk("flush_valid", {63'h0, op_valid}, 64'h0);
        chk("flush_payload", op_payload, 64'h0);
        chk("flush_dec_ready", {63'h0, dec_ready}, 64'h1);
        // A real dec_fire in the flush cycle is discarded
        flush = 1'b1;
        drive(5'd3, 5'd4, 64'hA8);
        step();
        flush = 1'b0; dec_valid = 1'b0;
        #1;
        chk("flush_drop_valid", {63'h0, op_valid}, 64'h0);
        step();

        // Async reset in HOLD
        drive(5'd3, 5'd4, 64'hA9);
        step();
        dec_valid = 1'b0;
        step();
        chk("areset_pre_valid", {63'h0, op_valid}, 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_valid", {63'h0, op_valid}, 64'h0);
        chk("areset_rs1", {32'h0, op_rs1}, 64'h0);
        chk("areset_rs2", {32'h0, op_rs2}, 64'h0);
        chk("areset_payload", op_payload, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("areset_dec_ready", {63'h0, dec_ready}, 64'h1);

        // Normal operation after reset
        op_ready = 1'b1;
        step();
        drive(5'd4, 5'd3, 64'hAA); push(32'h22, 32'h11, 64'hAA);
        step();
        dec_valid = 1'b0;
        repeat (3) step();
        chk("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
